// File: rtl/lock_access_ctrl.sv
// Access controller: round-robin arbitration between keypad and remote, serial code
// delivery to the lock core, verdict handling with timeout, failure lockout and door hold.
module lock_access_ctrl #(
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int OPEN_CYC    = 8,
  parameter int RSP_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [3:0] code0,
  input  logic [3:0] code1,
  output logic [1:0] grant,
  output logic       busy,
  output logic       lock_clr,
  output logic       lock_in,
  input  logic       lock_unlock,
  input  logic       lock_error,
  output logic       door_open,
  output logic       lockout,
  output logic [1:0] fail_cnt,
  output logic       timeout_err
);

  localparam int M0   = (RSP_TIMEOUT > 4) ? RSP_TIMEOUT : 4;
  localparam int M1   = (OPEN_CYC > M0) ? OPEN_CYC : M0;
  localparam int MAXC = (LOCKOUT_CYC > M1) ? LOCKOUT_CYC : M1;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SEND, WAIT, OPEN, LOCKOUT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      own, own_n;
  logic [3:0]      code, code_n;
  logic            last, last_n;
  logic [1:0]      fail_n, fail_inc;
  logic            tmo_n, pick;
  logic [1:0]      bidx;

  assign fail_inc = (fail_cnt >= 2'(MAX_FAIL)) ? fail_cnt : fail_cnt + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      own         <= '0;
      code        <= '0;
      last        <= 1'b1;  // requester 0 wins the first contest
      fail_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      own         <= own_n;
      code        <= code_n;
      last        <= last_n;
      fail_cnt    <= fail_n;
      timeout_err <= tmo_n;
    end
  end

  // cnt restarts at 0 on every state entry; each state reads it as its own elapsed-cycle index
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    own_n   = own;
    code_n  = code;
    last_n  = last;
    fail_n  = fail_cnt;
    tmo_n   = 1'b0;
    pick    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (req != 2'b00) begin
          pick    = (req == 2'b11) ? ~last : req[1];
          own_n   = pick ? 2'b10 : 2'b01;
          code_n  = pick ? code1 : code0;
          last_n  = pick;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        cnt_n   = '0;
        state_n = SEND;
      end
      SEND: begin
        if (cnt == CW'(3)) begin
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (lock_unlock && !lock_error) begin
          fail_n  = '0;
          cnt_n   = '0;
          state_n = OPEN;
        end else if (lock_error || cnt == CW'(RSP_TIMEOUT - 1)) begin
          tmo_n   = !lock_error;
          fail_n  = fail_inc;
          own_n   = '0;
          cnt_n   = '0;
          state_n = (fail_inc == 2'(MAX_FAIL)) ? LOCKOUT : IDLE;
        end
      end
      OPEN: begin
        if (cnt == CW'(OPEN_CYC - 1)) begin
          own_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      LOCKOUT: begin
        if (cnt == CW'(LOCKOUT_CYC - 1)) begin
          fail_n  = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        own_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bidx      = 2'd3 - cnt[1:0];
  assign grant     = own;
  assign busy      = (state == CLEAR) || (state == SEND) || (state == WAIT);
  assign lock_clr  = (state == CLEAR);
  assign lock_in   = (state == SEND) && code[bidx];
  assign door_open = (state == OPEN);
  assign lockout   = (state == LOCKOUT);

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed scenarios for lock_access_ctrl; per-cycle expected output vectors are queued
// ahead of each scenario and popped one per clock as the DUT runs.
module tb_lock_access_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = '0;
  logic [3:0] code0 = '0, code1 = '0;
  logic       lock_unlock = 1'b0, lock_error = 1'b0;
  logic [1:0] grant, fail_cnt;
  logic       busy, lock_clr, lock_in, door_open, lockout, timeout_err;

  int vectors = 0;
  int errors  = 0;
  logic [9:0] sb[$];
  logic [9:0] want;
  logic [9:0] obs;

  lock_access_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .code0(code0), .code1(code1),
    .grant(grant), .busy(busy), .lock_clr(lock_clr), .lock_in(lock_in),
    .lock_unlock(lock_unlock), .lock_error(lock_error), .door_open(door_open),
    .lockout(lockout), .fail_cnt(fail_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign obs = {grant, busy, lock_clr, lock_in, door_open, lockout, fail_cnt, timeout_err};

  function automatic logic [9:0] ev(logic [1:0] g, logic b, logic c, logic li, logic d,
                                    logic lo, logic [1:0] f, logic t);
    return {g, b, c, li, d, lo, f, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(logic [9:0] v, int n);
    for (int k = 0; k < n; k++) sb.push_back(v);
  endtask

  // CLEAR, four SEND cycles MSB first, first WAIT cycle
  task automatic push_attempt(logic [1:0] g, logic [3:0] cd, logic [1:0] f);
    sb.push_back(ev(g, 1, 1, 0, 0, 0, f, 0));
    for (int k = 3; k >= 0; k--) sb.push_back(ev(g, 1, 0, cd[k], 0, 0, f, 0));
    sb.push_back(ev(g, 1, 0, 0, 0, 0, f, 0));
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; lock_unlock = 1'b0; lock_error = 1'b0;
    tick(); tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; lock_unlock = 1'b1; code0 = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== 10'b0) begin
        errors++; $display("FAIL reset cyc %0d got %b want %b", i, obs, 10'b0);
      end
    end
    do_reset();
  endtask

  task automatic test_unlock();
    int n;
    do_reset();
    req = 2'b01; code0 = 4'b1010;
    push_attempt(2'b01, 4'b1010, 0);
    push_n(ev(2'b01, 0, 0, 0, 1, 0, 0, 0), 8);
    push_n(10'b0, 2);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      tick();
      want = sb.pop_front(); vectors++;
      if (obs !== want) begin
        errors++; $display("FAIL unlock cyc %0d got %b want %b", i, obs, want);
      end
      if (i == 0) req = 2'b00;
      if (i == 5) lock_unlock = 1'b1;
      if (i == 6) lock_unlock = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    req = 2'b11; code0 = 4'b0011; code1 = 4'b1100;
    push_attempt(2'b01, 4'b0011, 0);
    sb.push_back(ev(2'b00, 0, 0, 0, 0, 0, 1, 0));
    push_attempt(2'b10, 4'b1100, 1);
    sb.push_back(ev(2'b10, 0, 0, 0, 1, 0, 0, 0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      tick();
      want = sb.pop_front(); vectors++;
      if (obs !== want) begin
        errors++; $display("FAIL round_robin cyc %0d got %b want %b", i, obs, want);
      end
      if (i == 5) lock_error = 1'b1;
      if (i == 6) lock_error = 1'b0;
      if (i == 7) req = 2'b00;
      if (i == 12) lock_unlock = 1'b1;
    end
    lock_unlock = 1'b0;
  endtask

  // lock_error held high throughout: it only counts while in WAIT
  task automatic test_lockout();
    int n;
    do_reset();
    req = 2'b01; code0 = 4'b0101; lock_error = 1'b1;
    push_attempt(2'b01, 4'b0101, 0);
    sb.push_back(ev(2'b00, 0, 0, 0, 0, 0, 1, 0));
    push_attempt(2'b01, 4'b0101, 1);
    sb.push_back(ev(2'b00, 0, 0, 0, 0, 0, 2, 0));
    push_attempt(2'b01, 4'b0101, 2);
    push_n(ev(2'b00, 0, 0, 0, 0, 1, 3, 0), 16);
    sb.push_back(ev(2'b00, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(ev(2'b01, 1, 1, 0, 0, 0, 0, 0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      tick();
      want = sb.pop_front(); vectors++;
      if (obs !== want) begin
        errors++; $display("FAIL lockout cyc %0d got %b want %b", i, obs, want);
      end
    end
    req = 2'b00; lock_error = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req = 2'b10; code1 = 4'b1001;
    push_attempt(2'b10, 4'b1001, 0);
    push_n(ev(2'b10, 1, 0, 0, 0, 0, 0, 0), 7);
    sb.push_back(ev(2'b00, 0, 0, 0, 0, 0, 1, 1));
    push_attempt(2'b10, 4'b1001, 1);
    push_n(ev(2'b10, 1, 0, 0, 0, 0, 1, 0), 7);
    sb.push_back(ev(2'b10, 0, 0, 0, 1, 0, 0, 0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      tick();
      want = sb.pop_front(); vectors++;
      if (obs !== want) begin
        errors++; $display("FAIL timeout cyc %0d got %b want %b", i, obs, want);
      end
      if (i == 0) req = 2'b00;
      if (i == 13) req = 2'b10;
      if (i == 14) req = 2'b00;
      if (i == 26) lock_unlock = 1'b1;
    end
    lock_unlock = 1'b0;
  endtask

  task automatic test_both_verdicts();
    int n;
    do_reset();
    req = 2'b01; code0 = 4'b0110;
    push_attempt(2'b01, 4'b0110, 0);
    push_n(ev(2'b00, 0, 0, 0, 0, 0, 1, 0), 3);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      tick();
      want = sb.pop_front(); vectors++;
      if (obs !== want) begin
        errors++; $display("FAIL both_verdicts cyc %0d got %b want %b", i, obs, want);
      end
      if (i == 0) req = 2'b00;
      if (i == 5) begin lock_unlock = 1'b1; lock_error = 1'b1; end
      if (i == 6) begin lock_unlock = 1'b0; lock_error = 1'b0; end
    end
  endtask

  task automatic test_reset_mid_send();
    int n;
    do_reset();
    req = 2'b10; code1 = 4'b1111; code0 = 4'b0001;
    push_attempt(2'b10, 4'b1111, 0);
    sb.push_back(ev(2'b00, 0, 0, 0, 0, 0, 1, 0));
    sb.push_back(ev(2'b01, 1, 1, 0, 0, 0, 1, 0));
    sb.push_back(ev(2'b01, 1, 0, 0, 0, 0, 1, 0));
    sb.push_back(ev(2'b01, 1, 0, 0, 0, 0, 1, 0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      tick();
      want = sb.pop_front(); vectors++;
      if (obs !== want) begin
        errors++; $display("FAIL reset_mid pre cyc %0d got %b want %b", i, obs, want);
      end
      if (i == 0) req = 2'b00;
      if (i == 5) lock_error = 1'b1;
      if (i == 6) begin lock_error = 1'b0; req = 2'b01; end
      if (i == 7) req = 2'b00;
    end
    // now inside the 2nd SEND cycle of requester 0's attempt
    reset = 1'b1;
    #1;
    vectors++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL reset_mid async got %b want %b", obs, 10'b0);
    end
    tick();
    vectors++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL reset_mid held got %b want %b", obs, 10'b0);
    end
    reset = 1'b0;
    req = 2'b11;
    push_attempt(2'b01, 4'b0001, 0);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      tick();
      want = sb.pop_front(); vectors++;
      if (obs !== want) begin
        errors++; $display("FAIL reset_mid fresh cyc %0d got %b want %b", i, obs, want);
      end
      if (i == 0) req = 2'b00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unlock();
    test_round_robin();
    test_lockout();
    test_timeout();
    test_both_verdicts();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
